// File: rtl/rx_frame_ctrl.sv
// Receive-side frame controller: edge-detects the UART done flag, filters bad frames,
// buffers kept frames in a show-ahead FIFO and tracks overrun, error count and idle gaps.
module rx_frame_ctrl #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_done,
    input  logic [2:0]               rx_error,
    input  logic [7:0]               rx_data,
    input  logic                     drop_bad,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic [2:0]               out_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    output logic [7:0]               err_cnt,
    input  logic                     clr_status,
    output logic                     gap_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } gap_state_t;

    logic [7:0]    r_mem_data [DEPTH];
    logic [2:0]    r_mem_err  [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_done_q;
    logic          r_overrun;
    logic [7:0]    r_err_cnt;
    gap_state_t    r_gap_state;
    logic [GW-1:0] r_gap_cnt;
    logic          r_gap_pulse;

    logic w_ev;
    logic w_bad;
    logic w_push_req;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_lost;

    assign w_ev       = rx_done & ~r_done_q;
    assign w_bad      = |rx_error;
    assign w_push_req = w_ev & ~(w_bad & drop_bad);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_lost     = w_push_req & w_full & ~w_pop;

    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_err    = out_valid ? r_mem_err[r_rd_ptr]  : '0;
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
    assign err_cnt    = r_err_cnt;
    assign gap_pulse  = r_gap_pulse;

    // NOTE: storage is deliberately left out of reset; r_count gates every read, so stale
    // contents are never visible and the array can map onto plain RAM/flops without reset muxes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= rx_data;
            r_mem_err[r_wr_ptr]  <= rx_error;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q  <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_done_q <= rx_done;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);

            if (clr_status)  r_overrun <= 1'b0;
            else if (w_lost) r_overrun <= 1'b1;

            if (clr_status)                          r_err_cnt <= '0;
            else if (w_ev && w_bad && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Gap counter holds the cycles left before the pulse; it fires on the step to zero so the
    // pulse lands exactly GAP_CYCLES cycles after the last event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_state <= S_IDLE;
            r_gap_cnt   <= '0;
            r_gap_pulse <= 1'b0;
        end else begin
            r_gap_pulse <= 1'b0;
            if (w_ev) begin
                if (GAP_CYCLES == 1) begin
                    r_gap_state <= S_IDLE;
                    r_gap_pulse <= 1'b1;
                end else begin
                    r_gap_state <= S_ARMED;
                    r_gap_cnt   <= GW'(GAP_CYCLES - 1);
                end
            end else if (r_gap_state == S_ARMED) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
                if (r_gap_cnt == GW'(1)) begin
                    r_gap_state <= S_IDLE;
                    r_gap_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: a queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rx_frame_ctrl;

    localparam int DEPTH = 8;
    localparam int GAP   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_done = 1'b0;
    logic [2:0] rx_error = '0;
    logic [7:0] rx_data = '0;
    logic       drop_bad = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_status = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_err;
    logic [3:0] fifo_count;
    logic       overrun;
    logic [7:0] err_cnt;
    logic       gap_pulse;

    rx_frame_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_error(rx_error), .rx_data(rx_data),
        .drop_bad(drop_bad), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_err(out_err), .fifo_count(fifo_count), .overrun(overrun), .err_cnt(err_cnt),
        .clr_status(clr_status), .gap_pulse(gap_pulse)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules over a queue, updated at each active edge.
    logic [10:0] m_q[$];
    logic        m_done_q  = 1'b0;
    logic        m_ovr     = 1'b0;
    int          m_err     = 0;
    logic        m_pulse   = 1'b0;
    int          m_cyc     = 0;
    int          m_last_ev = -1000;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_done_q  = 1'b0;
            m_ovr     = 1'b0;
            m_err     = 0;
            m_pulse   = 1'b0;
            m_last_ev = -1000;
        end else begin
            automatic logic ev   = rx_done && !m_done_q;
            automatic logic bad  = |rx_error;
            automatic logic pop  = (m_q.size() != 0) && out_ready;
            automatic logic full = (m_q.size() == DEPTH);
            automatic logic lost = 1'b0;
            m_done_q = rx_done;
            if (pop) void'(m_q.pop_front());
            if (ev && !(bad && drop_bad)) begin
                if (!full || pop) m_q.push_back({rx_error, rx_data});
                else lost = 1'b1;
            end
            if (clr_status) begin
                m_err = 0;
                m_ovr = 1'b0;
            end else begin
                if (ev && bad && m_err < 255) m_err++;
                if (lost) m_ovr = 1'b1;
            end
            if (ev) m_last_ev = m_cyc;
            m_cyc++;
            m_pulse = (m_last_ev == m_cyc - GAP);
        end
    end

    // Per-cycle compare plus observers for gap pulses and popped bytes.
    int          gp_cnt  = 0;
    int          gp_last = -1;
    logic        log_en  = 1'b0;
    logic [7:0]  pop_log[$];

    always @(negedge clk) begin
        check("valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("data", out_data, m_q[0][7:0]);
            check("err", out_err, m_q[0][10:8]);
        end
        check("count", fifo_count, m_q.size());
        check("overrun", overrun, m_ovr);
        check("err_cnt", err_cnt, m_err);
        check("gap_pulse", gap_pulse, m_pulse);
        if (gap_pulse === 1'b1) begin
            gp_cnt++;
            gp_last = m_cyc;
        end
        if (log_en && out_valid && out_ready) pop_log.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [7:0] d, input logic [2:0] e, input int hold);
        rx_data  = d;
        rx_error = e;
        rx_done  = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
        tick();
    endtask

    initial begin
        int t0;
        int gp0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", fifo_count, 0);
        rst_n = 1'b1;
        tick();

        // No frame yet: the gap detector must stay silent.
        repeat (GAP + 10) tick();
        check("no_gap_without_frame", gp_cnt, 0);

        // Single frame held high for five cycles.
        frame(8'hA5, 3'b000, 5);
        @(negedge clk);
        check("single_count", fifo_count, 1);
        check("single_data", out_data, 8'hA5);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("single_popped", fifo_count, 0);

        // Drop policy.
        tick();
        drop_bad = 1'b1;
        frame(8'h3C, 3'b010, 1);
        @(negedge clk);
        check("drop_count", fifo_count, 0);
        check("drop_errcnt", err_cnt, 1);
        tick();
        drop_bad = 1'b0;
        frame(8'h3C, 3'b010, 1);
        @(negedge clk);
        check("keep_err", out_err, 3'b010);
        check("keep_errcnt", err_cnt, 2);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Overrun with the host stalled.
        for (int i = 0; i < 9; i++) frame(8'(i), 3'b000, 1);
        @(negedge clk);
        check("ovr_count", fifo_count, 8);
        check("ovr_flag", overrun, 1);
        check("ovr_head", out_data, 8'h00);
        tick();
        out_ready = 1'b1;
        rx_data   = 8'h09;
        rx_error  = 3'b000;
        rx_done   = 1'b1;
        tick();
        out_ready = 1'b0;
        rx_done   = 1'b0;
        @(negedge clk);
        check("full_pushpop_count", fifo_count, 8);
        check("full_pushpop_head", out_data, 8'h01);
        tick();
        clr_status = 1'b1;
        out_ready  = 1'b1;
        tick();
        clr_status = 1'b0;
        repeat (10) tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("ovr_cleared", overrun, 0);
        check("drained", fifo_count, 0);

        // Wrap and ordering with an irregular ready pattern.
        tick();
        log_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 3 != 2);
            frame(8'h10 + 8'(i), 3'b000, 1);
        end
        out_ready = 1'b1;
        repeat (12) tick();
        out_ready = 1'b0;
        log_en    = 1'b0;
        check("wrap_popped", pop_log.size(), 20);
        for (int i = 0; i < pop_log.size(); i++) check("wrap_order", pop_log[i], 8'h10 + 8'(i));
        check("wrap_no_ovr", overrun, 0);

        // Gap detection: events at t0 and t0+10, single pulse at t0+26.
        repeat (GAP + 4) tick();
        gp0 = gp_cnt;
        t0  = m_cyc;
        frame(8'h55, 3'b000, 1);
        repeat (8) tick();
        frame(8'h56, 3'b000, 1);
        repeat (30) tick();
        check("gap_pulses", gp_cnt - gp0, 1);
        check("gap_cycle", gp_last, t0 + 26);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;

        // Saturation and clear priority.
        drop_bad = 1'b1;
        for (int i = 0; i < 300; i++) frame(8'hEE, 3'b001, 1);
        @(negedge clk);
        check("err_sat", err_cnt, 255);
        tick();
        clr_status = 1'b1;
        frame(8'hEE, 3'b100, 1);
        clr_status = 1'b0;
        @(negedge clk);
        check("clr_priority", err_cnt, 0);
        tick();
        drop_bad = 1'b0;

        // Reset mid-burst, with the done flag still high at release.
        for (int i = 0; i < 4; i++) frame(8'h40 + 8'(i), 3'b001, 1);
        rx_data  = 8'h77;
        rx_error = 3'b000;
        rx_done  = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_errcnt", err_cnt, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_pulse", gap_pulse, 0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("release_ev_valid", out_valid, 1);
        check("release_ev_data", out_data, 8'h77);
        check("release_ev_count", fifo_count, 1);
        rx_done = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
